// File: rtl/ula_multiciclo.sv
// Multi-cycle 74181-style ALU: one 4-bit slice per clock, LSB first, with the
// slice carry registered between cycles. Results are published on entry to DONE.
module ula_multiciclo_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] f,
    output logic       cout,
    output logic       c3
);
    logic [3:0] x, y, lf, sum;
    logic       co;

    always_comb begin
        x  = 4'h0;
        y  = 4'h0;
        lf = 4'h0;
        case (s)
            4'h0: begin lf = ~a;       x = a;       y = 4'h0;    end
            4'h1: begin lf = ~(a | b); x = a | b;   y = 4'h0;    end
            4'h2: begin lf = ~a & b;   x = a | ~b;  y = 4'h0;    end
            4'h3: begin lf = 4'h0;     x = 4'h0;    y = 4'hF;    end
            4'h4: begin lf = ~(a & b); x = a;       y = a & ~b;  end
            4'h5: begin lf = ~b;       x = a | b;   y = a & ~b;  end
            4'h6: begin lf = a ^ b;    x = a;       y = ~b;      end
            4'h7: begin lf = a & ~b;   x = a & ~b;  y = 4'hF;    end
            4'h8: begin lf = a & b;    x = a;       y = a & b;   end
            4'h9: begin lf = ~(a ^ b); x = a;       y = b;       end
            4'hA: begin lf = b;        x = a | ~b;  y = a & b;   end
            4'hB: begin lf = ~a | b;   x = a & b;   y = 4'hF;    end
            4'hC: begin lf = 4'hF;     x = a;       y = a;       end
            4'hD: begin lf = a | ~b;   x = a | b;   y = a;       end
            4'hE: begin lf = a | b;    x = a | ~b;  y = a;       end
            4'hF: begin lf = a;        x = a;       y = 4'hF;    end
        endcase
        {co, sum} = {1'b0, x} + {1'b0, y} + {4'h0, cin};
        if (m) begin
            f    = lf;
            cout = 1'b0;
            c3   = 1'b0;
        end else begin
            f    = sum;
            cout = co;
            // carry into bit 3 recovered from the sum bit
            c3   = x[3] ^ y[3] ^ sum[3];
        end
    end
endmodule

module ula_multiciclo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             a_eq_b
);
    localparam int N  = WIDTH / 4;
    localparam int IW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic [3:0]       s_r, sl_f;
    logic             m_r, carry, c3_r, eq_r, sl_cout, sl_c3, last;

    assign last = (idx == IW'(N));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    ula_multiciclo_slice u_slice (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .s    (s_r),
        .m    (m_r),
        .cin  (carry),
        .f    (sl_f),
        .cout (sl_cout),
        .c3   (sl_c3)
    );

    // Operands shift down a nibble per slice; results fill acc from the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            s_r    <= 4'h0;
            m_r    <= 1'b0;
            carry  <= 1'b0;
            c3_r   <= 1'b0;
            eq_r   <= 1'b0;
            f      <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            a_eq_b <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    s_r   <= s;
                    m_r   <= m;
                    carry <= c_in;
                    eq_r  <= (a == b);
                    idx   <= '0;
                end
                RUN: if (!last) begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    acc   <= (acc >> 4) | (WIDTH'(sl_f) << (WIDTH - 4));
                    carry <= sl_cout;
                    c3_r  <= sl_c3;
                    idx   <= idx + 1'b1;
                end else begin
                    f      <= acc;
                    c_out  <= carry;
                    ovf    <= carry ^ c3_r;
                    zero   <= (acc == '0);
                    a_eq_b <= eq_r;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_multiciclo.sv
// Bench for ula_multiciclo: directed cases plus random operations on 16- and
// 4-bit instances, checked against a whole-word arithmetic reference model.
module tb_ula_multiciclo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start, m, c_in, busy, done, c_out, ovf, zero, a_eq_b;
    logic [15:0] a, b, f;
    logic [3:0]  s;
    logic        start4, m4, c_in4, busy4, done4, c_out4, ovf4, zero4, a_eq_b4;
    logic [3:0]  a4, b4, f4, s4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] f;
        logic        c;
        logic        v;
        logic        z;
        logic        e;
    } exp_t;

    ula_multiciclo #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .s(s), .m(m),
        .c_in(c_in), .busy(busy), .done(done), .f(f), .c_out(c_out), .ovf(ovf),
        .zero(zero), .a_eq_b(a_eq_b));

    ula_multiciclo #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .s(s4), .m(m4),
        .c_in(c_in4), .busy(busy4), .done(done4), .f(f4), .c_out(c_out4), .ovf(ovf4),
        .zero(zero4), .a_eq_b(a_eq_b4));

    // Whole-word reference: F = X + Y + cin computed in one addition.
    function automatic exp_t model(input logic [15:0] ta, tb, input logic [3:0] ts,
                                   input logic tm, tc, input int w);
        exp_t r;
        logic [31:0] mask, aa, bb, x, y, sum, lo;
        mask = (32'd1 << w) - 1;
        aa = {16'h0, ta} & mask;
        bb = {16'h0, tb} & mask;
        x = 0;
        y = 0;
        r = '0;
        if (tm) begin
            case (ts)
                4'h0: x = ~aa;         4'h1: x = ~(aa | bb);
                4'h2: x = ~aa & bb;    4'h3: x = 0;
                4'h4: x = ~(aa & bb);  4'h5: x = ~bb;
                4'h6: x = aa ^ bb;     4'h7: x = aa & ~bb;
                4'h8: x = aa & bb;     4'h9: x = ~(aa ^ bb);
                4'hA: x = bb;          4'hB: x = ~aa | bb;
                4'hC: x = mask;        4'hD: x = aa | ~bb;
                4'hE: x = aa | bb;     4'hF: x = aa;
            endcase
            sum = x & mask;
            r.f = sum[15:0];
        end else begin
            case (ts)
                4'h0: begin x = aa;       y = 0;        end
                4'h1: begin x = aa | bb;  y = 0;        end
                4'h2: begin x = aa | ~bb; y = 0;        end
                4'h3: begin x = 0;        y = mask;     end
                4'h4: begin x = aa;       y = aa & ~bb; end
                4'h5: begin x = aa | bb;  y = aa & ~bb; end
                4'h6: begin x = aa;       y = ~bb;      end
                4'h7: begin x = aa & ~bb; y = mask;     end
                4'h8: begin x = aa;       y = aa & bb;  end
                4'h9: begin x = aa;       y = bb;       end
                4'hA: begin x = aa | ~bb; y = aa & bb;  end
                4'hB: begin x = aa & bb;  y = mask;     end
                4'hC: begin x = aa;       y = aa;       end
                4'hD: begin x = aa | bb;  y = aa;       end
                4'hE: begin x = aa | ~bb; y = aa;       end
                4'hF: begin x = aa;       y = mask;     end
            endcase
            x = x & mask;
            y = y & mask;
            sum = x + y + {31'h0, tc};
            lo = (x & (mask >> 1)) + (y & (mask >> 1)) + {31'h0, tc};
            r.f = sum[15:0] & mask[15:0];
            r.c = sum[w];
            r.v = sum[w] ^ lo[w-1];
        end
        r.z = (r.f == 16'h0);
        r.e = (aa == bb);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One operation; inputs (and start) are scrambled while busy to prove latching.
    task automatic run_op(input int w, input logic [15:0] ta, tb, input logic [3:0] ts,
                          input logic tm, tc, input string tag);
        exp_t e;
        int cyc;
        logic d;
        e = model(ta, tb, ts, tm, tc, w);
        cyc = 0;
        @(negedge clk);
        if (w == 16) begin a = ta; b = tb; s = ts; m = tm; c_in = tc; start = 1'b1; end
        else begin a4 = ta[3:0]; b4 = tb[3:0]; s4 = ts; m4 = tm; c_in4 = tc; start4 = 1'b1; end
        @(posedge clk); #1;
        do begin
            if (w == 16) begin
                start = 1'($urandom); a = 16'($urandom); b = 16'($urandom);
                s = 4'($urandom); m = 1'($urandom); c_in = 1'($urandom);
            end else begin
                start4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
                s4 = 4'($urandom); m4 = 1'($urandom); c_in4 = 1'($urandom);
            end
            @(posedge clk); cyc++; #1;
            d = (w == 16) ? done : done4;
        end while (!d && cyc < 20);
        start = 1'b0;
        start4 = 1'b0;
        chk({tag, ".lat"}, 16'(cyc), (w == 16) ? 16'd5 : 16'd2);
        if (w == 16) begin
            chk({tag, ".f"}, f, e.f);
            chk({tag, ".c_out"}, 16'(c_out), 16'(e.c));
            chk({tag, ".ovf"}, 16'(ovf), 16'(e.v));
            chk({tag, ".zero"}, 16'(zero), 16'(e.z));
            chk({tag, ".a_eq_b"}, 16'(a_eq_b), 16'(e.e));
            chk({tag, ".busy"}, 16'(busy), 16'd1);
        end else begin
            chk({tag, ".f"}, 16'(f4), e.f);
            chk({tag, ".c_out"}, 16'(c_out4), 16'(e.c));
            chk({tag, ".ovf"}, 16'(ovf4), 16'(e.v));
            chk({tag, ".zero"}, 16'(zero4), 16'(e.z));
            chk({tag, ".a_eq_b"}, 16'(a_eq_b4), 16'(e.e));
        end
        @(posedge clk); #1;
        chk({tag, ".pulse"}, (w == 16) ? 16'(done) : 16'(done4), 16'd0);
    endtask

    initial begin
        int ndone;
        start = 0; a = 0; b = 0; s = 0; m = 0; c_in = 0;
        start4 = 0; a4 = 0; b4 = 0; s4 = 0; m4 = 0; c_in4 = 0;

        #12;
        chk("rst.busy", 16'(busy), 16'd0);
        chk("rst.done", 16'(done), 16'd0);
        chk("rst.f", f, 16'h0);
        chk("rst.c_out", 16'(c_out), 16'd0);
        chk("rst.ovf", 16'(ovf), 16'd0);
        chk("rst.zero", 16'(zero), 16'd0);
        chk("rst.a_eq_b", 16'(a_eq_b), 16'd0);
        chk("rst.busy4", 16'(busy4), 16'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed vectors
        run_op(16, 16'h00FF, 16'h0001, 4'h9, 1'b0, 1'b0, "add_carry");
        run_op(16, 16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, "add_wrap");
        run_op(16, 16'h7FFF, 16'h0001, 4'h9, 1'b0, 1'b0, "add_ovf");
        run_op(16, 16'h0005, 16'h0007, 4'h6, 1'b0, 1'b1, "sub_borrow");
        run_op(16, 16'h1234, 16'h1234, 4'h6, 1'b0, 1'b1, "sub_eq");
        run_op(16, 16'hF0F0, 16'hFF00, 4'h6, 1'b1, 1'b0, "xor_logic");
        run_op(16, 16'h0000, 16'h0000, 4'h3, 1'b0, 1'b0, "minus_one");
        run_op(16, 16'h8000, 16'h0000, 4'hC, 1'b0, 1'b0, "double_ovf");
        run_op(4, 16'h0008, 16'h0000, 4'hC, 1'b0, 1'b0, "w4_double");

        // start held through RUN and DONE: exactly one operation
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; s = 4'h9; m = 1'b0; c_in = 1'b0; start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("hold_start.ndone", 16'(ndone), 16'd1);
        chk("hold_start.busy", 16'(busy), 16'd0);
        chk("hold_start.f", f, 16'h3333);

        // Reset during the second RUN cycle aborts the operation
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; s = 4'h9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 16'(busy), 16'd0);
        chk("abort.done", 16'(done), 16'd0);
        chk("abort.f", f, 16'h0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort.no_done", 16'(ndone), 16'd0);
        run_op(16, 16'h0F0F, 16'h0101, 4'h9, 1'b0, 1'b0, "after_abort");

        // Random operations
        for (int i = 0; i < 40; i++)
            run_op(16, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
                   1'($urandom), $sformatf("rnd16_%0d", i));
        for (int i = 0; i < 16; i++)
            run_op(4, 16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom),
                   1'($urandom), $sformatf("rnd4_%0d", i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ula_multiciclo.md
ULA_MULTICICLO -- requirements
Module: ula_multiciclo

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4 and >= 4.
REQ-002 Derived constant N = WIDTH/4, number of 4-bit slices per operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a, b  input  WIDTH each  operands.
REQ-007 s  input  4  function select {S3,S2,S1,S0}.
REQ-008 m  input  1  1 = logic mode, 0 = arithmetic mode.
REQ-009 c_in  input  1  carry-in to slice 0.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse; result outputs valid that cycle.
REQ-012 f  output  WIDTH  registered result.
REQ-013 c_out  output  1  carry out of MSB slice.
REQ-014 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-015 zero  output  1  high when f == 0.
REQ-016 a_eq_b  output  1  high when latched a == latched b.

Function
REQ-017 FSM states: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after slice N-1; DONE->IDLE unconditionally.
REQ-018 On accepting start, a, b, s, m, c_in SHALL be latched; later input changes SHALL not affect the operation.
REQ-019 RUN processes exactly one 4-bit slice per cycle, LSB slice first, index 0..N-1; slice carry-out registered and used as next slice's carry-in.
REQ-020 Latency: start sampled at edge T -> done high during cycle after edge T+N+1 (WIDTH=16: done 5 cycles after start edge).
REQ-021 start while busy (RUN or DONE) SHALL be ignored, including start during DONE.
REQ-022 f, c_out, ovf, zero, a_eq_b SHALL update only on the edge entering DONE and hold until the next DONE.
REQ-023 Logic mode (m=1), bitwise, c_out=0, ovf=0: 0 ~A; 1 ~(A|B); 2 ~A&B; 3 0; 4 ~(A&B); 5 ~B; 6 A^B; 7 A&~B; 8 A&B; 9 ~(A^B); A B; B ~A|B; C all-ones; D A|~B; E A|B; F A.
REQ-024 Arithmetic mode (m=0): F = X + Y + c_in over full WIDTH, X/Y bitwise so slice carries chain exactly: 0 A+0; 1 (A|B)+0; 2 (A|~B)+0; 3 0+all-ones; 4 A+(A&~B); 5 (A|B)+(A&~B); 6 A+~B; 7 (A&~B)+all-ones; 8 A+(A&B); 9 A+B; A (A|~B)+(A&B); B (A&B)+all-ones; C A+A; D (A|B)+A; E (A|~B)+A; F A+all-ones.
REQ-025 c_out SHALL be the true carry of the WIDTH-bit sum, never inverted (s=6, c_in=1: c_out=1 means no borrow).
REQ-026 All-ones constants SHALL be WIDTH bits wide (sliced per nibble as 4'hF).
REQ-027 zero and a_eq_b SHALL be computed from the final full-width values, not per slice.

Reset
REQ-028 rst_n low SHALL force IDLE, slice index 0, busy=0, done=0, f=0, c_out=0, ovf=0, zero=0, a_eq_b=0, independent of clk.
REQ-029 Reset asserted mid-RUN SHALL abort; no done pulse for the aborted operation; first start after release behaves per REQ-020.

Verification
REQ-030 WIDTH=16, m=0, s=9, a=16'h00FF, b=16'h0001, c_in=0 -> f=16'h0100, c_out=0, ovf=0, zero=0, done 5 cycles after start.
REQ-031 m=0, s=9, a=16'hFFFF, b=16'h0001 -> f=0, c_out=1, zero=1; a=16'h7FFF, b=16'h0001 -> f=16'h8000, ovf=1, c_out=0.
REQ-032 m=0, s=6, c_in=1, a=16'h0005, b=16'h0007 -> f=16'hFFFE, c_out=0; a=b=16'h1234 -> f=0, c_out=1, zero=1, a_eq_b=1.
REQ-033 m=1, s=6, a=16'hF0F0, b=16'hFF00 -> f=16'h0FF0, c_out=0, a_eq_b=0; inputs changed during RUN do not alter f.
REQ-034 start pulsed in RUN and DONE -> ignored, single done; rst_n low in 2nd RUN cycle -> busy=0, done=0, f=0 immediately, no done follows.
REQ-035 WIDTH=4 instance, m=0, s=C, a=4'h8, c_in=0 -> f=4'h0, c_out=1, ovf=1, zero=1, done 2 cycles after start.
